cam_frame_capture: RTL and testbench

//  Consumes the IO-registered DVP camera bus (cam_dat/href/vsync, already sampled in the IO cells on
//  the camera pixel clock) and captures one decimated RGB565 frame on request. Pairs bytes into
//  16-bit pixels, keeps 1 of every 2^DEC_SHIFT columns and rows, and writes them to a dual-port

---
 rtl/cam_pkg.sv | 21 ++
 rtl/cam_byte_packer.sv | 51 +++++
 rtl/cam_frame_capture.sv | 145 ++++++++++++++
 tb/tb_cam_frame_capture.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared types and default geometry for the DVP frame capture block.
// Holds the capture FSM encoding, pixel width and the 640x480 / 2^4 decimation defaults.
package cam_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_SYNC = 2'd1,
        ST_WAIT_FALL = 2'd2,
        ST_CAPTURE   = 2'd3
    } cap_state_t;

    localparam int RGB565_W = 16;
    localparam int BYTE_W   = 8;
    localparam int CNT_W    = 10;

    localparam int H_PIXELS_DEF  = 640;
    localparam int V_LINES_DEF   = 480;
    localparam int DEC_SHIFT_DEF = 4;
    localparam int WORDS_PER_FRAME_DEF = (H_PIXELS_DEF * V_LINES_DEF) >> (2 * DEC_SHIFT_DEF);

endpackage

// File: rtl/cam_byte_packer.sv
// Pairs DVP bytes into 16-bit pixels while a line is active and counts pixel columns.
// The pixel strobe is combinational on the second byte so the caller can register it once.
module cam_byte_packer
    import cam_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [BYTE_W-1:0]   cam_dat,
    input  logic                cam_href,
    output logic                pix_vld_p0,
    output logic [RGB565_W-1:0] pix_data_p0,
    output logic [CNT_W-1:0]    pix_col_p0
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic              byte_phase;
    logic [BYTE_W-1:0] hi_byte;
    logic [CNT_W-1:0]  col;

    // Phase/column clear whenever the line is inactive, so a trailing odd byte is simply lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_phase <= 1'b0;
            col        <= '0;
        end else if (!en || !cam_href) begin
            byte_phase <= 1'b0;
            col        <= '0;
        end else if (!byte_phase) begin
            byte_phase <= 1'b1;
        end else begin
            byte_phase <= 1'b0;
            col        <= sat_inc(col);
        end
    end

    always_ff @(posedge clk) begin
        if (en && cam_href && !byte_phase) begin
            hi_byte <= cam_dat;
        end
    end

    // ---- p0: pixel complete on the cycle its second byte is on the bus ----
    assign pix_vld_p0  = en & cam_href & byte_phase;
    assign pix_data_p0 = {hi_byte, cam_dat};
    assign pix_col_p0  = col;

endmodule

// File: rtl/cam_frame_capture.sv
// Captures one decimated RGB565 frame from the registered DVP bus into a frame RAM on request.
// Edge detection, row counting, decimation, addressing and the arm/capture FSM live here.
module cam_frame_capture
    import cam_pkg::*;
#(
    parameter int H_PIXELS   = H_PIXELS_DEF,
    parameter int V_LINES    = V_LINES_DEF,
    parameter int DEC_SHIFT  = DEC_SHIFT_DEF,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BYTE_W-1:0]     cam_dat,
    input  logic                  cam_href,
    input  logic                  cam_vsync,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  frame_err,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [RGB565_W-1:0]   wr_data
);

    localparam logic [CNT_W-1:0] H_LIM    = CNT_W'(H_PIXELS);
    localparam logic [CNT_W-1:0] V_LIM    = CNT_W'(V_LINES);
    localparam logic [CNT_W-1:0] DEC_MASK = CNT_W'((1 << DEC_SHIFT) - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    cap_state_t state, state_nxt;

    logic                  vsync_d, href_d;
    logic [CNT_W-1:0]      row;
    logic                  line_err;
    logic [ADDR_WIDTH-1:0] addr_cnt;

    logic                  pix_vld_p0;
    logic [RGB565_W-1:0]   pix_data_p0;
    logic [CNT_W-1:0]      pix_col_p0;

    logic                  capturing, vsync_rise, vsync_fall;
    logic                  line_end, line_bad, wr_hit, err_final;
    logic [CNT_W-1:0]      row_final;

    assign capturing  = (state == ST_CAPTURE);
    assign vsync_rise = cam_vsync & ~vsync_d;
    assign vsync_fall = ~cam_vsync & vsync_d;
    assign line_end   = capturing & href_d & ~cam_href;
    assign line_bad   = (pix_col_p0 != H_LIM);

    cam_byte_packer u_packer (
        .clk         (clk),
        .reset       (reset),
        .en          (capturing),
        .cam_dat     (cam_dat),
        .cam_href    (cam_href),
        .pix_vld_p0  (pix_vld_p0),
        .pix_data_p0 (pix_data_p0),
        .pix_col_p0  (pix_col_p0)
    );

    // Keep only in-frame pixels whose row and column both sit on the decimation grid.
    assign wr_hit = pix_vld_p0
                  && (pix_col_p0 < H_LIM) && (row < V_LIM)
                  && ((pix_col_p0 & DEC_MASK) == '0)
                  && ((row & DEC_MASK) == '0);

    // A line ending in the same cycle as the closing vsync edge still counts toward the frame.
    assign row_final = line_end ? sat_inc(row) : row;
    assign err_final = line_err | (line_end & line_bad) | (row_final != V_LIM);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (start)      state_nxt = ST_WAIT_SYNC;
            ST_WAIT_SYNC: if (cam_vsync)  state_nxt = ST_WAIT_FALL;
            ST_WAIT_FALL: if (vsync_fall) state_nxt = ST_CAPTURE;
            ST_CAPTURE:   if (vsync_rise) state_nxt = ST_IDLE;
            default:                      state_nxt = ST_IDLE;
        endcase
    end

    // ---- p1: registered RAM write port and status ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vsync_d   <= 1'b0;
            href_d    <= 1'b0;
            row       <= '0;
            line_err  <= 1'b0;
            addr_cnt  <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            vsync_d <= cam_vsync;
            href_d  <= cam_href;
            wr_en   <= wr_hit;

            if (wr_hit) begin
                wr_data  <= pix_data_p0;
                wr_addr  <= addr_cnt;
                addr_cnt <= addr_cnt + 1'b1;
            end

            if (state == ST_WAIT_FALL && vsync_fall) begin
                row      <= '0;
                line_err <= 1'b0;
                addr_cnt <= '0;
                wr_addr  <= '0;
            end else if (line_end) begin
                row <= sat_inc(row);
                if (line_bad) begin
                    line_err <= 1'b1;
                end
            end

            if (state == ST_IDLE && start) begin
                busy      <= 1'b1;
                done      <= 1'b0;
                frame_err <= 1'b0;
            end

            if (capturing && vsync_rise) begin
                busy      <= 1'b0;
                done      <= 1'b1;
                frame_err <= err_final;
            end
        end
    end

endmodule

// File: tb/tb_cam_frame_capture.sv
// Directed bench for cam_frame_capture on a reduced 32x16 geometry with 4x decimation.
// A frame-level model turns per-line byte counts into the expected write list.
module tb_cam_frame_capture;

    localparam int H    = 32;
    localparam int V    = 16;
    localparam int DS   = 2;
    localparam int D    = 1 << DS;
    localparam int AW   = 11;
    localparam int WPF  = (H / D) * (V / D);
    localparam int MAXL = 24;

    logic          clk;
    logic          reset;
    logic [7:0]    cam_dat;
    logic          cam_href;
    logic          cam_vsync;
    logic          start;
    logic          busy;
    logic          done;
    logic          frame_err;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;

    cam_frame_capture #(
        .H_PIXELS   (H),
        .V_LINES    (V),
        .DEC_SHIFT  (DS),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cam_dat   (cam_dat),
        .cam_href  (cam_href),
        .cam_vsync (cam_vsync),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .frame_err (frame_err),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    typedef struct {
        int          r;
        int          p;
        int          addr;
        logic [15:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          line_len   [0:MAXL-1];
    int          line_start [0:MAXL-1];
    logic [15:0] mem        [0:(1<<AW)-1];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          wr_count = 0;
    int          wc0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] byte_val(input int r, input int k);
        return (k % 2 == 0) ? 8'(r) : 8'(k / 2);
    endfunction

    // Model: every row on the grid, every completed pixel on the grid up to H, addresses dense from 0.
    task automatic build_expect(input int nl);
        exp_t e;
        int   np;
        int   a = 0;
        exp_q.delete();
        for (int r = 0; r < nl; r++) begin
            if (r < V && r % D == 0) begin
                np = line_len[r] / 2;
                if (np > H) np = H;
                for (int p = 0; p < np; p++) begin
                    if (p % D == 0) begin
                        e.r = r; e.p = p; e.addr = a;
                        e.data = {byte_val(r, 2*p), byte_val(r, 2*p+1)};
                        exp_q.push_back(e);
                        a++;
                    end
                end
            end
        end
    endtask

    function automatic logic exp_err(input int nl);
        logic e = (nl != V);
        for (int r = 0; r < nl; r++) if (line_len[r] / 2 != H) e = 1'b1;
        return e;
    endfunction

    // Compare process: each write must be the next model entry, one cycle after its second byte.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (wr_en === 1'b1) begin
            mem[wr_addr] = wr_data;
            wr_count++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got addr %0d data %0h, required no write", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(wr_addr), e.addr);
                check("wr_data", 32'(wr_data), 32'(e.data));
                check("wr_latency", cyc, line_start[e.r] + 2*e.p + 2);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lines();
        for (int r = 0; r < MAXL; r++) line_len[r] = 2 * H;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < (1 << AW); i++) mem[i] = 16'hDEAD;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic vsync_pulse();
        cam_href  = 1'b0;
        cam_vsync = 1'b1;
        repeat (4) tick();
        cam_vsync = 1'b0;
        repeat (3) tick();
    endtask

    task automatic drive_lines(input int n, input int start_line, input int rst_line);
        for (int r = 0; r < n; r++) begin
            line_start[r] = cyc;
            for (int k = 0; k < line_len[r]; k++) begin
                cam_href = 1'b1;
                cam_dat  = byte_val(r, k);
                start    = (r == start_line && k == 0);
                if (r == rst_line && k == 0) reset = 1'b1;
                tick();
                start = 1'b0;
                if (reset) begin
                    reset = 1'b0;
                    check("rst_mid_wr_en",   32'(wr_en),   0);
                    check("rst_mid_busy",    32'(busy),    0);
                    check("rst_mid_done",    32'(done),    0);
                    check("rst_mid_wr_addr", 32'(wr_addr), 0);
                end
            end
            cam_href = 1'b0;
            repeat (4) tick();
        end
    endtask

    task automatic capture_frame(input int nl, input int start_line);
        build_expect(nl);
        vsync_pulse();
        drive_lines(nl, start_line, -1);
        vsync_pulse();
    endtask

    initial begin
        reset = 1'b1; cam_dat = '0; cam_href = 1'b0; cam_vsync = 1'b0; start = 1'b0;
        set_lines();
        clear_mem();
        repeat (3) tick();
        check("reset_busy",      32'(busy),      0);
        check("reset_done",      32'(done),      0);
        check("reset_frame_err", 32'(frame_err), 0);
        check("reset_wr_en",     32'(wr_en),     0);
        check("reset_wr_addr",   32'(wr_addr),   0);
        check("reset_wr_data",   32'(wr_data),   0);
        reset = 1'b0;
        repeat (2) tick();

        // Full nominal frame.
        pulse_start();
        check("t1_busy_armed", 32'(busy), 1);
        check("t1_done_armed", 32'(done), 0);
        build_expect(V);
        check("model_size",  exp_q.size(), WPF);
        check("model_addr9", 32'(exp_q[9].data), 32'h0404);
        wc0 = wr_count;
        capture_frame(V, -1);
        check("t1_writes",    wr_count - wc0, 32);
        check("t1_pending",   exp_q.size(), 0);
        check("t1_done",      32'(done), 1);
        check("t1_busy",      32'(busy), 0);
        check("t1_frame_err", 32'(frame_err), 32'(exp_err(V)));
        check("t1_mem9",      32'(mem[9]),  32'h0404);
        check("t1_mem31",     32'(mem[31]), 32'h0C1C);

        // Armed mid-frame: the remainder of that frame must produce nothing.
        exp_q.delete();
        wc0 = wr_count;
        vsync_pulse();
        drive_lines(V, 3, -1);
        check("t2_busy_mid", 32'(busy), 1);
        check("t2_done_mid", 32'(done), 0);
        capture_frame(V, -1);
        check("t2_writes",  wr_count - wc0, 32);
        check("t2_pending", exp_q.size(), 0);
        check("t2_done",    32'(done), 1);
        check("t2_err",     32'(frame_err), 0);

        // Short line 5.
        line_len[5] = 2 * (H - 2);
        wc0 = wr_count;
        pulse_start();
        capture_frame(V, -1);
        check("t3_writes",    wr_count - wc0, 32);
        check("t3_err",       32'(frame_err), 1);
        check("t3_err_model", 32'(frame_err), 32'(exp_err(V)));
        set_lines();

        // Line 3 carries one trailing odd byte.
        line_len[3] = 2 * H + 1;
        clear_mem();
        wc0 = wr_count;
        pulse_start();
        capture_frame(V, -1);
        check("t4_writes", wr_count - wc0, 32);
        check("t4_err",    32'(frame_err), 0);
        check("t4_mem8",   32'(mem[8]), 32'h0400);
        set_lines();

        // Reset at the start of line 9, then a clean capture.
        wc0 = wr_count;
        pulse_start();
        build_expect(9);
        vsync_pulse();
        drive_lines(V, -1, 9);
        check("t5_writes_before_rst", wr_count - wc0, 24);
        check("t5_pending",           exp_q.size(), 0);
        vsync_pulse();
        check("t5_idle_busy", 32'(busy), 0);
        clear_mem();
        wc0 = wr_count;
        pulse_start();
        capture_frame(V, -1);
        check("t5_writes", wr_count - wc0, 32);
        check("t5_mem0",   32'(mem[0]), 32'h0000);
        check("t5_done",   32'(done), 1);

        // Extra start while busy plus two excess lines; a further frame must stay uncaptured.
        wc0 = wr_count;
        pulse_start();
        capture_frame(V + 2, 2);
        check("t6_writes",  wr_count - wc0, 32);
        check("t6_err",     32'(frame_err), 1);
        check("t6_done",    32'(done), 1);
        check("t6_busy",    32'(busy), 0);
        check("t6_pending", exp_q.size(), 0);
        wc0 = wr_count;
        drive_lines(V, -1, -1);
        vsync_pulse();
        check("t6_no_recapture", wr_count - wc0, 0);
        check("t6_busy_after",   32'(busy), 0);
        check("t6_done_after",   32'(done), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
